mux_scan_n: RTL

- Parametrised, registered N:1 multiplexer of W-bit channels; next generation of the gate-level 4:1 mux.
- Two operating modes:
  - MANUAL: an external select chooses the channel.
  - SCAN: an internal round-robin scanner visits every enabled channel for DWELL cycles each.
- Sits between multi-channel data sources and a single display or serial consumer.
- Reports which channel is presented and flags the end of each full scan pass.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_n_rr_next_ch.sv | 44 ++++
 rtl/mux_scan_n.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the registered N:1 scanning multiplexer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter width for a modulo-depth counter; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_n_rr_next_ch.sv
// Round-robin lookup: next enabled channel strictly after i_cur, circularly.
module rr_next_ch #(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [SW-1:0] i_cur,
  input  logic [N-1:0]  i_mask,
  output logic [SW-1:0] o_next,
  output logic          o_wrap,
  output logic          o_any
);

  logic [N-1:0]  w_above;
  logic          w_hi_found;
  logic [SW-1:0] w_hi_idx;
  logic [SW-1:0] w_lo_idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_above
      assign w_above[gi] = i_mask[gi] && (SW'(gi) > i_cur);
    end
  endgenerate

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_above[k]) begin
        w_hi_found = 1'b1;
        w_hi_idx   = SW'(k);
      end
      if (i_mask[k]) begin
        w_lo_idx = SW'(k);
      end
    end
  end

  assign o_any  = |i_mask;
  assign o_wrap = o_any && !w_hi_found;
  assign o_next = w_hi_found ? w_hi_idx : (o_any ? w_lo_idx : i_cur);

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with manual select and a round-robin scan mode.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] data_in,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   ch_mask,
  input  logic           hold,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  output logic           scan_wrap
);

  localparam int DW = cnt_width(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_cur_ch;
  logic [DW-1:0] r_dwell;
  logic          r_wrap_pend;
  logic [W-1:0]  r_out;
  logic [SW-1:0] r_out_ch;
  logic          r_out_valid;
  logic          r_scan_wrap;

  logic [W-1:0]  w_ch [N];
  logic [W-1:0]  w_sel_data;
  logic [W-1:0]  w_cur_data;
  logic          w_sel_en;
  logic          w_cur_en;
  logic [SW-1:0] w_next;
  logic          w_wrap;
  logic          w_any;
  logic          w_advance;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign w_ch[gi] = data_in[gi*W +: W];
    end
  endgenerate

  // Indices at or beyond N match no channel, so they read as disabled zero data.
  always_comb begin
    w_sel_data = '0;
    w_cur_data = '0;
    w_sel_en   = 1'b0;
    w_cur_en   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        w_sel_data = w_ch[k];
        w_sel_en   = ch_mask[k];
      end
      if (r_cur_ch == SW'(k)) begin
        w_cur_data = w_ch[k];
        w_cur_en   = ch_mask[k];
      end
    end
  end

  rr_next_ch #(.N(N)) u_rr_next_ch (
    .i_cur  (r_cur_ch),
    .i_mask (ch_mask),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_any  (w_any)
  );

  // A masked current channel forces an advance even while hold is asserted.
  assign w_advance = !w_cur_en || (!hold && (r_dwell == DWELL_LAST));

  always_comb begin
    if (mode == MODE_MANUAL) begin
      w_state_next = ST_MANUAL;
    end else if ((mode == MODE_SCAN) && w_any) begin
      w_state_next = ST_SCAN;
    end else begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_MANUAL;
      r_cur_ch    <= '0;
      r_dwell     <= '0;
      r_wrap_pend <= 1'b0;
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_scan_wrap <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (w_state_next)
        ST_MANUAL: begin
          r_out       <= w_sel_en ? w_sel_data : '0;
          r_out_ch    <= sel;
          r_out_valid <= w_sel_en;
          r_scan_wrap <= 1'b0;
          r_cur_ch    <= sel;
          r_dwell     <= '0;
        end
        ST_SCAN: begin
          r_out       <= w_cur_data;
          r_out_ch    <= r_cur_ch;
          r_out_valid <= w_cur_en;
          // The wrap is announced together with the first word of the wrapped channel.
          r_scan_wrap <= r_wrap_pend && (r_state == ST_SCAN);
          if (w_advance) begin
            r_cur_ch    <= w_next;
            r_dwell     <= '0;
            r_wrap_pend <= w_wrap;
          end else begin
            r_wrap_pend <= 1'b0;
            if (!hold) begin
              r_dwell <= r_dwell + DW'(1);
            end
          end
        end
        default: begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
          r_scan_wrap <= 1'b0;
          r_dwell     <= '0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign scan_wrap = r_scan_wrap;

endmodule
